// File: rtl/dm_arbiter.sv
// dm_arbiter: shares the single-port data memory between the CPU datapath
// (port 0) and the host/debug port (port 1). At most one access is granted
// per cycle. Memory controls are registered. Read data returns to the
// winning port two cycles after its grant.
// Optional feature: define DM_ARB_LOCK_EN to build the lock owner and the
// LOCK_MAX burst counter. Without it the lock inputs are ignored and the
// arbiter is a plain round-robin.
module dm_arbiter #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 12,
   parameter int LOCK_MAX = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req0_i,
   input  logic              req1_i,
   input  logic              we0_i,
   input  logic              we1_i,
   input  logic [ADDR_W-1:0] addr0_i,
   input  logic [ADDR_W-1:0] addr1_i,
   input  logic [DATA_W-1:0] wdata0_i,
   input  logic [DATA_W-1:0] wdata1_i,
   input  logic              lock0_i,
   input  logic              lock1_i,
   output logic              gnt0_o,
   output logic              gnt1_o,
   output logic              rvalid0_o,
   output logic              rvalid1_o,
   output logic [DATA_W-1:0] rdata_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic [DATA_W-1:0] mem_rdata_i
);

   // Port that wins when both are eligible; moves to the other port on every grant.
   logic ptr;

   logic elig0;
   logic elig1;
   logic win_vld;
   logic win_id;
   logic              win_we;
   logic [ADDR_W-1:0] win_addr;
   logic [DATA_W-1:0] win_wdata;

   // Read pipeline: stage 1 follows the grant, stage 2 follows the memory read.
   logic rd1_v;
   logic rd1_id;
   logic rd2_v;
   logic rd2_id;

`ifdef DM_ARB_LOCK_EN
   localparam int CNT_W = $clog2(LOCK_MAX + 1);

   logic             own_vld;
   logic             own_id;
   logic [CNT_W-1:0] lock_cnt;
   logic             lock_hold;
   logic             lock_forced;
   logic             win_lock;

   // Ownership continues while the owner keeps both req and lock high.
   always_comb begin
      lock_hold   = 1'b0;
      lock_forced = 1'b0;
      if (own_vld) begin
         lock_hold = own_id ? (req1_i && lock1_i) : (req0_i && lock0_i);
      end
      lock_forced = lock_hold && (lock_cnt == CNT_W'(LOCK_MAX));
   end
`else
   logic unused_lock;
   localparam int unused_lock_max = LOCK_MAX;
   assign unused_lock = lock0_i ^ lock1_i;
`endif

   // Eligibility and winner selection for the access sampled at this edge.
   // NOTE: every output of a combinational block gets a default first, so no path can leave a latch behind.
   always_comb begin
      elig0 = req0_i && !gnt0_o;
      elig1 = req1_i && !gnt1_o;
`ifdef DM_ARB_LOCK_EN
      if (lock_hold && !lock_forced) begin
         elig0 = !own_id;
         elig1 = own_id;
      end else if (lock_forced) begin
         // Burst limit reached: the owner yields if the other port is waiting.
         if (own_id) begin
            elig1 = !req0_i;
         end else begin
            elig0 = !req1_i;
         end
      end
`endif
      win_vld = elig0 || elig1;
      win_id  = (elig0 && elig1) ? ptr : elig1;
   end

   // Request fields of the winning port.
   always_comb begin
      win_we    = win_id ? we1_i    : we0_i;
      win_addr  = win_id ? addr1_i  : addr0_i;
      win_wdata = win_id ? wdata1_i : wdata0_i;
`ifdef DM_ARB_LOCK_EN
      win_lock  = win_id ? lock1_i  : lock0_i;
`endif
   end

   // Grant pulses, registered memory controls and the priority pointer.
   // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         gnt0_o      <= 1'b0;
         gnt1_o      <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= '0;
         mem_wdata_o <= '0;
         ptr         <= 1'b0;
      end else begin
         gnt0_o   <= win_vld && !win_id;
         gnt1_o   <= win_vld && win_id;
         mem_we_o <= win_vld && win_we;
         if (win_vld) begin
            mem_addr_o  <= win_addr;
            mem_wdata_o <= win_wdata;
            ptr         <= !win_id;
         end
      end
   end

   // Read return: tag reads at grant, capture memory data two cycles later.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd1_v     <= 1'b0;
         rd1_id    <= 1'b0;
         rd2_v     <= 1'b0;
         rd2_id    <= 1'b0;
         rvalid0_o <= 1'b0;
         rvalid1_o <= 1'b0;
         rdata_o   <= '0;
      end else begin
         rd1_v     <= win_vld && !win_we;
         rd1_id    <= win_id;
         rd2_v     <= rd1_v;
         rd2_id    <= rd1_id;
         rvalid0_o <= rd2_v && !rd2_id;
         rvalid1_o <= rd2_v && rd2_id;
         if (rd2_v) begin
            rdata_o <= mem_rdata_i;
         end
      end
   end

`ifdef DM_ARB_LOCK_EN
   // Lock owner tracking and consecutive-grant counter.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         own_vld  <= 1'b0;
         own_id   <= 1'b0;
         lock_cnt <= '0;
      end else if (win_vld && win_lock) begin
         if (lock_hold && !lock_forced && (win_id == own_id)) begin
            lock_cnt <= lock_cnt + 1'b1;
         end else begin
            own_vld  <= 1'b1;
            own_id   <= win_id;
            lock_cnt <= CNT_W'(1);
         end
      end else begin
         own_vld  <= 1'b0;
         lock_cnt <= '0;
      end
   end
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: directed bench for dm_arbiter with a synchronous memory model.
// Inputs change and outputs are sampled 1 ns after each rising clock edge.
module tb_dm_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0, req1, we0, we1, lock0, lock1;
   logic [11:0] addr0, addr1;
   logic [31:0] wdata0, wdata1;
   logic        gnt0, gnt1, rvalid0, rvalid1;
   logic [31:0] rdata;
   logic        mem_we;
   logic [11:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   logic [31:0] mem [4096];
   int          tests = 0;
   int          fails = 0;
   logic        both_gnt_seen = 1'b0;
   logic        both_rv_seen  = 1'b0;
   int          exp_g [9];
   int          code;

   always #5 clk = ~clk;

   dm_arbiter dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .req0_i      (req0),
      .req1_i      (req1),
      .we0_i       (we0),
      .we1_i       (we1),
      .addr0_i     (addr0),
      .addr1_i     (addr1),
      .wdata0_i    (wdata0),
      .wdata1_i    (wdata1),
      .lock0_i     (lock0),
      .lock1_i     (lock1),
      .gnt0_o      (gnt0),
      .gnt1_o      (gnt1),
      .rvalid0_o   (rvalid0),
      .rvalid1_o   (rvalid1),
      .rdata_o     (rdata),
      .mem_we_o    (mem_we),
      .mem_addr_o  (mem_addr),
      .mem_wdata_o (mem_wdata),
      .mem_rdata_i (mem_rdata)
   );

   // Single-port synchronous memory: read data valid one cycle after the address.
   always @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
   end

   // Mutual-exclusion monitor.
   always @(negedge clk) begin
      if (gnt0 && gnt1) both_gnt_seen <= 1'b1;
      if (rvalid0 && rvalid1) both_rv_seen <= 1'b1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1;
      req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
      for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
      mem[12'h005] = 32'hDEADBEEF;

      // Reset state
      repeat (2) tick();
      rst = 1'b0;
      check("rst_gnt", {62'd0, gnt0, gnt1}, 64'd0);
      check("rst_rvalid", {62'd0, rvalid0, rvalid1}, 64'd0);
      check("rst_rdata", rdata, 64'd0);
      check("rst_mem_we", mem_we, 64'd0);
      check("rst_mem_addr", mem_addr, 64'd0);
      check("rst_mem_wdata", mem_wdata, 64'd0);
      tick();

      // Single read by port 0 from 0x005
      req0 = 1; we0 = 0; addr0 = 12'h005;
      tick();
      check("rd_gnt0", gnt0, 64'd1);
      check("rd_gnt1", gnt1, 64'd0);
      check("rd_mem_addr", mem_addr, 64'h005);
      check("rd_mem_we", mem_we, 64'd0);
      req0 = 0;
      tick();
      check("rd_c2_rvalid0", rvalid0, 64'd0);
      tick();
      check("rd_c3_rvalid0", rvalid0, 64'd1);
      check("rd_c3_rvalid1", rvalid1, 64'd0);
      check("rd_c3_rdata", rdata, 64'hDEADBEEF);
      tick();
      check("rd_c4_rvalid0", rvalid0, 64'd0);
      check("rd_c4_rdata_hold", rdata, 64'hDEADBEEF);

      // Mid-cycle reset clears outputs immediately
      #3 rst = 1'b1;
      #1;
      check("midrst_rdata", rdata, 64'd0);
      check("midrst_mem_addr", mem_addr, 64'd0);
      tick();
      rst = 1'b0;

      // Contention: port 0 reads 0x010, port 1 writes 0x1234 to 0x010
      req0 = 1; we0 = 0; addr0 = 12'h010;
      req1 = 1; we1 = 1; addr1 = 12'h010; wdata1 = 32'h0000_1234;
      tick();
      check("cont_c1_gnt0", gnt0, 64'd1);
      check("cont_c1_gnt1", gnt1, 64'd0);
      tick();
      check("cont_c2_gnt1", gnt1, 64'd1);
      check("cont_c2_mem_we", mem_we, 64'd1);
      check("cont_c2_mem_addr", mem_addr, 64'h010);
      check("cont_c2_mem_wdata", mem_wdata, 64'h1234);
      tick();
      check("cont_c3_gnt0", gnt0, 64'd1);
      check("cont_c3_rvalid0", rvalid0, 64'd1);
      check("cont_c3_rdata_old", rdata, 64'd0);
      tick();
      check("cont_c4_gnt1", gnt1, 64'd1);
      check("cont_c4_rvalid1", rvalid1, 64'd0);
      tick();
      check("cont_c5_gnt0", gnt0, 64'd1);
      check("cont_c5_rvalid0", rvalid0, 64'd1);
      check("cont_c5_rdata_new", rdata, 64'h1234);
      req0 = 0; req1 = 0; we1 = 0;
      tick();
      tick();
      check("cont_c7_rvalid0", rvalid0, 64'd1);
      check("cont_c7_rdata", rdata, 64'h1234);
      tick();

      // Write by port 1 to the top address
      req1 = 1; we1 = 1; addr1 = 12'hFFF; wdata1 = 32'hA5A5A5A5;
      tick();
      check("wr_gnt1", gnt1, 64'd1);
      check("wr_mem_we", mem_we, 64'd1);
      check("wr_mem_addr", mem_addr, 64'hFFF);
      check("wr_mem_wdata", mem_wdata, 64'hA5A5A5A5);
      req1 = 0; we1 = 0;
      tick();
      check("wr_c2_mem_we", mem_we, 64'd0);
      check("wr_c2_addr_hold", mem_addr, 64'hFFF);
      tick();
      check("wr_c3_rvalid", {62'd0, rvalid0, rvalid1}, 64'd0);

      // Read back the written word through port 0
      req0 = 1; we0 = 0; addr0 = 12'hFFF;
      tick();
      check("rb_gnt0", gnt0, 64'd1);
      req0 = 0;
      tick();
      tick();
      check("rb_rvalid0", rvalid0, 64'd1);
      check("rb_rdata", rdata, 64'hA5A5A5A5);
      tick();

      // Lock: port 0 locked, port 1 requesting continuously
      rst = 1'b1;
      tick();
      rst = 1'b0;
`ifdef DM_ARB_LOCK_EN
      exp_g = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
`else
      exp_g = '{0, 1, 0, 1, 0, 1, 0, 1, 0};
`endif
      req0 = 1; we0 = 0; addr0 = 12'h005; lock0 = 1;
      req1 = 1; we1 = 0; addr1 = 12'h005; lock1 = 0;
      for (int i = 1; i <= 9; i++) begin
         tick();
         code = gnt0 ? 0 : (gnt1 ? 1 : 2);
         check($sformatf("lock_gnt_c%0d", i), 64'(code), 64'(exp_g[i-1]));
      end
      req0 = 0; req1 = 0; lock0 = 0;
      repeat (4) tick();

      // Reset during a read discards it
      req0 = 1; we0 = 0; addr0 = 12'h005;
      tick();
      check("rstrd_gnt0", gnt0, 64'd1);
      req0 = 0;
      tick();
      rst = 1'b1;
      #3 rst = 1'b0;
      tick();
      check("rstrd_c3_rvalid0", rvalid0, 64'd0);
      tick();
      check("rstrd_c4_rvalid0", rvalid0, 64'd0);
      req0 = 1;
      tick();
      check("rstrd_next_gnt0", gnt0, 64'd1);
      req0 = 0;
      tick();
      tick();
      check("rstrd_next_rvalid0", rvalid0, 64'd1);
      check("rstrd_next_rdata", rdata, 64'hDEADBEEF);
      tick();

      check("never_dual_gnt", both_gnt_seen, 64'd0);
      check("never_dual_rvalid", both_rv_seen, 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
